data_bus_ctrl: RTL and testbench
================================

// Module: data_bus_ctrl
// PURPOSE
//  Parametrised successor to the data-side address decoder. Sits between the core's data port and
//  NUM_MEM data memory banks plus an on-chip MMIO page (LED register, button input). Registers the
//  decode and drives active-low bank selects. Runs a valid/ready request and response handshake.
//  Waits on per-bank acks, hosts the LED/BTN registers, and returns a bus error on unmapped
//  accesses or bank timeout.
// PARAMETERS
//  ADDR_W      32          address width
//  DATA_W      32          data width
//  NUM_MEM     2           number of memory banks (power of 2, >=2)
//  BANK_LSB    17          lowest address bit of bank index; index = addr[BANK_LSB +: $clog2(NUM_MEM)]
//  MMIO_BASE   32'h4000    MMIO page base (4 KiB aligned); LED at +0x0, BTN at +0x4
//  LED_W       16          LED register width
//  BTN_W       5           button input width
//  TIMEOUT     15          max cycles waiting for bank ack before error (>=1)
// PORTS
//  clk         in   1                clock, rising edge
//  rst_n       in   1                asynchronous, active-low reset
//  req_valid   in   1                core request valid
//  req_ready   out  1                request accepted this cycle when req_valid & req_ready
//  req_we      in   1                1 = write, 0 = read
//  req_addr    in   ADDR_W           byte address
//  req_wdata   in   DATA_W           write data
//  rsp_valid   out  1                response valid (one-cycle pulse; core always accepts)
//  rsp_rdata   out  DATA_W           read data (0 for writes and errors)
//  rsp_err     out  1                bus error, qualified by rsp_valid
//  mem_sel_n   out  NUM_MEM          bank chip selects, active LOW, at most one low
//  mem_ack     in   NUM_MEM          bank access complete, sampled only for selected bank
//  mem_rdata   in   NUM_MEM*DATA_W   bank read data, bank i at [i*DATA_W +: DATA_W]
//  led_out     out  LED_W            LED register
//  btn_in      in   BTN_W            raw asynchronous buttons
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0.
//   - mem_sel_n=all 1, led_out=0, button sync flops=0, timeout counter=0.
//   - Reset mid-transaction drops it silently; no response is issued.
//  Decode at acceptance (MMIO wins over banks):
//   - addr[ADDR_W-1:12]==MMIO_BASE[ADDR_W-1:12]: offset 0x0 LED (RW); offset 0x4 BTN (RO, write ignored,
//     no error); any other offset -> error.
//   - Otherwise -> bank index per BANK_LSB. Address bits above the index are ignored (aliasing).
//  FSM
//   - IDLE: req_ready=1. On accept:
//     - MMIO hit -> MMIO; LED write takes effect on the accept edge.
//     - Bank hit -> MEM; that mem_sel_n bit goes low the next cycle. Counter is cleared.
//     - Bad offset -> ERR.
//   - MEM: req_ready=0, selected mem_sel_n held low.
//     - ack of selected bank -> RSP with rdata = that bank's data (0 if write), err=0.
//     - Counter reaches TIMEOUT without ack -> RSP with err=1, rdata=0.
//     - mem_sel_n deasserts on the same edge. Ack and timeout in the same cycle: ack wins.
//   - MMIO: one cycle; -> RSP, rdata = zero-extended led_out or synced btn, err=0.
//   - ERR: one cycle; -> RSP, err=1.
//   - RSP: rsp_valid=1 for exactly one cycle, req_ready=0; -> IDLE.
//  Latency (accept edge to rsp_valid): MMIO/error = 2 cycles; bank = 2 + ack wait cycles.
//  Handshake rules
//   - One outstanding request; req_ready low from accept until the cycle after rsp_valid.
//   - Inputs are sampled only at accept; later changes are ignored.
//   - Acks from non-selected banks and acks in IDLE are ignored.
//  Buttons: 2-flop synchroniser, so BTN read reflects btn_in from >=2 cycles earlier.
//   All outputs are registered.
// STRUCTURE
//  - Shared header data_bus_defs.vh: FSM state encodings (IDLE, MEM, MMIO, ERR, RSP), MMIO offsets
//    LED_OFS=12'h000, BTN_OFS=12'h004, and the default MMIO_BASE.
//  - One sub-module: sync_2ff #(.W(BTN_W)), reused later for other async inputs.
//  - FSM, decode and timeout counter are inline.
// TESTING
//  1. Reset: assert rst_n=0 mid-MEM -> mem_sel_n=2'b11, led_out=0, req_ready=1 asynchronously, no rsp_valid.
//  2. Write 0x0000_4000 data 0xA5A5 -> led_out=16'hA5A5. Read 0x4000 -> rsp_rdata=0xA5A5, err=0,
//     rsp 2 cycles after accept.
//  3. Read 0x0002_0010 (bit17=1) -> mem_sel_n=2'b01. Ack after 3 cycles with bank1 data 0xDEAD_BEEF
//     -> rsp_rdata=0xDEADBEEF. Same for 0x10 -> mem_sel_n=2'b10.
//  4. Bank read with no ack -> rsp_err=1 after TIMEOUT cycles, mem_sel_n returns to all 1.
//     Ack on exactly the timeout cycle -> err=0.
//  5. btn_in=5'b10101 held -> BTN read (0x4004) returns 0x15. Write to 0x4004 -> err=0, led_out unchanged.
//     Read 0x4008 -> rsp_err=1.
//  6. Back-to-back valid requests -> second accepted only after rsp_valid. Stray mem_ack in IDLE
//     -> no response. NUM_MEM=4 build: bank index from bits 18:17.

Source files
------------

// File: rtl/data_bus_ctrl_pkg.sv
// Shared definitions for the data-side bus controller: FSM state encodings,
// MMIO register offsets, the default MMIO page base and the MMIO offset decoder.
package data_bus_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MEM  = 3'd1,
    ST_MMIO = 3'd2,
    ST_ERR  = 3'd3,
    ST_RSP  = 3'd4
  } state_t;

  // Which MMIO register an accepted request addresses.
  typedef enum logic [1:0] {
    MMIO_LED  = 2'd0,
    MMIO_BTN  = 2'd1,
    MMIO_NONE = 2'd2
  } mmio_reg_t;

  localparam logic [11:0] LED_OFS           = 12'h000;
  localparam logic [11:0] BTN_OFS           = 12'h004;
  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0000_4000;

  // Map a 12-bit page offset onto the MMIO register it selects.
  function automatic mmio_reg_t mmio_decode(input logic [11:0] ofs);
    case (ofs)
      LED_OFS: return MMIO_LED;
      BTN_OFS: return MMIO_BTN;
      default: return MMIO_NONE;
    endcase
  endfunction

endpackage

// File: rtl/data_bus_ctrl_sync_2ff.sv
// Two-flop synchroniser for a bus of independent asynchronous inputs.
// Each bit is synchronised on its own; no coherency between bits is implied.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_reg;
  logic [W-1:0] sync_reg;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/data_bus_ctrl.sv
// Data-side bus controller: decodes core requests onto NUM_MEM memory banks
// (active-low selects, ack handshake with timeout) or a small MMIO page
// (LED register, synchronised buttons). One request outstanding at a time;
// every response is a single-cycle rsp_valid pulse with registered data/error.
module data_bus_ctrl
  import data_bus_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                NUM_MEM   = 2,
  parameter int                BANK_LSB  = 17,
  parameter logic [ADDR_W-1:0] MMIO_BASE = ADDR_W'(MMIO_BASE_DEFAULT),
  parameter int                LED_W     = 16,
  parameter int                BTN_W     = 5,
  parameter int                TIMEOUT   = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [NUM_MEM-1:0]        mem_sel_n,
  input  logic [NUM_MEM-1:0]        mem_ack,
  input  logic [NUM_MEM*DATA_W-1:0] mem_rdata,
  output logic [LED_W-1:0]          led_out,
  input  logic [BTN_W-1:0]          btn_in
);

  localparam int BANK_W = $clog2(NUM_MEM);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  state_t              state_reg,     state_next;
  logic                we_reg,        we_next;
  logic [BANK_W-1:0]   bank_reg,      bank_next;
  mmio_reg_t           mmio_sel_reg,  mmio_sel_next;
  logic [CNT_W-1:0]    cnt_reg,       cnt_next;
  logic                req_ready_reg, req_ready_next;
  logic                rsp_valid_reg, rsp_valid_next;
  logic                rsp_err_reg,   rsp_err_next;
  logic [DATA_W-1:0]   rsp_rdata_reg, rsp_rdata_next;
  logic [NUM_MEM-1:0]  mem_sel_n_reg, mem_sel_n_next;
  logic [LED_W-1:0]    led_reg,       led_next;

  logic [BTN_W-1:0]    btn_sync;
  logic [DATA_W-1:0]   bank_rdata [NUM_MEM];
  logic                req_mmio_page;
  mmio_reg_t           req_mmio_reg;
  logic [BANK_W-1:0]   req_bank;

  sync_2ff #(.W(BTN_W)) u_btn_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (btn_sync)
  );

  // Split the flat bank read-data bus into one word per bank.
  for (genvar gi = 0; gi < NUM_MEM; gi++) begin : g_bank
    assign bank_rdata[gi] = mem_rdata[gi*DATA_W +: DATA_W];
  end

  // Only the low LED_W bits of write data ever land anywhere.
  if (DATA_W > LED_W) begin : g_wdata_tail
    logic unused_wdata_tail;
    assign unused_wdata_tail = ^req_wdata[DATA_W-1:LED_W];
  end

  // Request decode; the MMIO page takes priority over the bank window.
  assign req_mmio_page = (req_addr[ADDR_W-1:12] == MMIO_BASE[ADDR_W-1:12]);
  assign req_mmio_reg  = mmio_decode(req_addr[11:0]);
  assign req_bank      = req_addr[BANK_LSB +: BANK_W];

  // State and every output register; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      we_reg        <= 1'b0;
      bank_reg      <= '0;
      mmio_sel_reg  <= MMIO_LED;
      cnt_reg       <= '0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
      mem_sel_n_reg <= '1;
      led_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      we_reg        <= we_next;
      bank_reg      <= bank_next;
      mmio_sel_reg  <= mmio_sel_next;
      cnt_reg       <= cnt_next;
      req_ready_reg <= req_ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_rdata_reg <= rsp_rdata_next;
      mem_sel_n_reg <= mem_sel_n_next;
      led_reg       <= led_next;
    end
  end

  // Next-state logic; outputs are computed one cycle ahead so they leave registered.
  always_comb begin
    state_next     = state_reg;
    we_next        = we_reg;
    bank_next      = bank_reg;
    mmio_sel_next  = mmio_sel_reg;
    cnt_next       = cnt_reg;
    req_ready_next = 1'b0;
    rsp_valid_next = 1'b0;
    rsp_err_next   = 1'b0;
    rsp_rdata_next = '0;
    mem_sel_n_next = mem_sel_n_reg;
    led_next       = led_reg;

    case (state_reg)
      ST_IDLE: begin
        req_ready_next = 1'b1;
        if (req_valid && req_ready_reg) begin
          req_ready_next = 1'b0;
          we_next        = req_we;
          if (req_mmio_page) begin
            mmio_sel_next = req_mmio_reg;
            if (req_mmio_reg == MMIO_NONE) begin
              state_next = ST_ERR;
            end else begin
              state_next = ST_MMIO;
              // LED write lands on the accept edge; BTN writes are dropped silently.
              if (req_we && req_mmio_reg == MMIO_LED) begin
                led_next = req_wdata[LED_W-1:0];
              end
            end
          end else begin
            state_next     = ST_MEM;
            bank_next      = req_bank;
            cnt_next       = '0;
            mem_sel_n_next = ~(NUM_MEM'(1) << req_bank);
          end
        end
      end

      ST_MEM: begin
        // Ack is checked before the timeout so a last-cycle ack still succeeds.
        if (mem_ack[bank_reg]) begin
          state_next     = ST_RSP;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = we_reg ? '0 : bank_rdata[bank_reg];
          mem_sel_n_next = '1;
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          state_next     = ST_RSP;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
          mem_sel_n_next = '1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      ST_MMIO: begin
        state_next     = ST_RSP;
        rsp_valid_next = 1'b1;
        if (!we_reg) begin
          rsp_rdata_next = (mmio_sel_reg == MMIO_BTN) ? DATA_W'(btn_sync) : DATA_W'(led_reg);
        end
      end

      ST_ERR: begin
        state_next     = ST_RSP;
        rsp_valid_next = 1'b1;
        rsp_err_next   = 1'b1;
      end

      ST_RSP: begin
        state_next     = ST_IDLE;
        req_ready_next = 1'b1;
      end

      default: begin
        state_next     = ST_IDLE;
        req_ready_next = 1'b1;
        mem_sel_n_next = '1;
      end
    endcase
  end

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign mem_sel_n = mem_sel_n_reg;
  assign led_out   = led_reg;

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Bench for data_bus_ctrl: a table of single transactions on the default
// two-bank build, hand sequences for back-to-back requests, stray acks and
// reset mid-transaction, and a four-bank build for bank-index decode.
module tb_data_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  mem_sel_n, mem_ack;
  logic [63:0] mem_rdata;
  logic [15:0] led_out;
  logic [4:0]  btn_in;

  logic        req_valid4, req_we4;
  logic [31:0] req_addr4, req_wdata4;
  logic        req_ready4, rsp_valid4, rsp_err4;
  logic [31:0] rsp_rdata4;
  logic [3:0]  mem_sel_n4, mem_ack4;
  logic [127:0] mem_rdata4;
  logic [15:0] led_out4;
  logic [4:0]  btn_in4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_bus_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_sel_n(mem_sel_n), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .led_out(led_out), .btn_in(btn_in)
  );

  data_bus_ctrl #(.NUM_MEM(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_we(req_we4), .req_addr(req_addr4), .req_wdata(req_wdata4),
    .rsp_valid(rsp_valid4), .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4),
    .mem_sel_n(mem_sel_n4), .mem_ack(mem_ack4), .mem_rdata(mem_rdata4),
    .led_out(led_out4), .btn_in(btn_in4)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_wait;   // MEM cycles before ack is driven; -1 = never
    logic [1:0]  ack_mask;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;    // accept edge to first edge showing rsp_valid
    logic [1:0]  exp_sel;    // mem_sel_n in the cycle after accept
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs [14];

  logic [31:0] a4 [4];
  logic [3:0]  e4 [4];
  logic [31:0] d4 [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge one cycle after the response.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int ack_wait, input logic [1:0] ack_mask,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output logic [1:0] sel_first, output logic [1:0] sel_at_rsp,
                         output logic ready_at_rsp, output logic after_ok);
    int guard;
    guard = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    // scramble request inputs: the DUT must have captured them at accept
    req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wdata;
    lat = 1;
    sel_first = mem_sel_n;
    while (!rsp_valid && lat < 40) begin
      mem_ack = (ack_wait >= 0 && lat == ack_wait + 1) ? ack_mask : 2'b00;
      @(negedge clk);
      lat++;
    end
    mem_ack = 2'b00;
    rdata = rsp_rdata; err = rsp_err; sel_at_rsp = mem_sel_n; ready_at_rsp = req_ready;
    @(negedge clk);
    after_ok = !rsp_valid && req_ready;
  endtask

  initial begin
    logic [31:0] rdata;
    logic        err, ready_at_rsp, after_ok;
    logic [1:0]  sel_first, sel_at_rsp;
    int          lat, cnt, guard;
    logic [8:0]  rdy_seen, rsp_seen;

    //          we    addr          wdata         wait mask   rdata         err  lat sel    led
    vecs[0]  = '{1'b1, 32'h0000_4000, 32'h0000_A5A5, -1, 2'b00, 32'h0,        1'b0, 2, 2'b11, 16'hA5A5};
    vecs[1]  = '{1'b0, 32'h0000_4000, 32'h0,         -1, 2'b00, 32'h0000_A5A5, 1'b0, 2, 2'b11, 16'hA5A5};
    vecs[2]  = '{1'b0, 32'h0002_0010, 32'h0,          3, 2'b10, 32'hDEAD_BEEF, 1'b0, 5, 2'b01, 16'hA5A5};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,          3, 2'b01, 32'h1234_5678, 1'b0, 5, 2'b10, 16'hA5A5};
    vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         -1, 2'b00, 32'h0,        1'b1, 16, 2'b10, 16'hA5A5};
    vecs[5]  = '{1'b0, 32'h0002_0000, 32'h0,         14, 2'b10, 32'hDEAD_BEEF, 1'b0, 16, 2'b01, 16'hA5A5};
    vecs[6]  = '{1'b0, 32'h0000_4004, 32'h0,         -1, 2'b00, 32'h0000_0015, 1'b0, 2, 2'b11, 16'hA5A5};
    vecs[7]  = '{1'b1, 32'h0000_4004, 32'h0000_FFFF, -1, 2'b00, 32'h0,        1'b0, 2, 2'b11, 16'hA5A5};
    vecs[8]  = '{1'b0, 32'h0000_4008, 32'h0,         -1, 2'b00, 32'h0,        1'b1, 2, 2'b11, 16'hA5A5};
    vecs[9]  = '{1'b1, 32'h0002_0004, 32'h0000_0055,  0, 2'b10, 32'h0,        1'b0, 2, 2'b01, 16'hA5A5};
    vecs[10] = '{1'b0, 32'h8002_0000, 32'h0,          1, 2'b10, 32'hDEAD_BEEF, 1'b0, 3, 2'b01, 16'hA5A5};
    vecs[11] = '{1'b1, 32'h0000_4000, 32'h1234_00FF, -1, 2'b00, 32'h0,        1'b0, 2, 2'b11, 16'h00FF};
    vecs[12] = '{1'b0, 32'h0002_0000, 32'h0,          0, 2'b01, 32'h0,        1'b1, 16, 2'b01, 16'h00FF};
    vecs[13] = '{1'b0, 32'h0000_4FFC, 32'h0,         -1, 2'b00, 32'h0,        1'b1, 2, 2'b11, 16'h00FF};

    a4[0] = 32'h0004_0000; e4[0] = 4'b1011; d4[0] = 32'hB000_0002;
    a4[1] = 32'h0006_0010; e4[1] = 4'b0111; d4[1] = 32'hB000_0003;
    a4[2] = 32'h0009_0000; e4[2] = 4'b1110; d4[2] = 32'hB000_0000;
    a4[3] = 32'h0002_0000; e4[3] = 4'b1101; d4[3] = 32'hB000_0001;

    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    mem_ack = 2'b00; mem_rdata = {32'hDEAD_BEEF, 32'h1234_5678};
    btn_in = 5'b10101;
    req_valid4 = 1'b0; req_we4 = 1'b0; req_addr4 = '0; req_wdata4 = '0;
    mem_ack4 = 4'b0000; btn_in4 = 5'b00000;
    mem_rdata4 = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};

    // reset state
    repeat (3) @(negedge clk);
    check("rst.req_ready", {31'b0, req_ready}, 32'h1);
    check("rst.rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst.rsp_err", {31'b0, rsp_err}, 32'h0);
    check("rst.rsp_rdata", rsp_rdata, 32'h0);
    check("rst.mem_sel_n", {30'b0, mem_sel_n}, 32'h3);
    check("rst.led_out", {16'b0, led_out}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // single-transaction table
    for (int i = 0; i < 14; i++) begin
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ack_wait, vecs[i].ack_mask,
              rdata, err, lat, sel_first, sel_at_rsp, ready_at_rsp, after_ok);
      $display("txn v%0d we=%0b addr=%h rdata=%h err=%0b lat=%0d", i, vecs[i].we, vecs[i].addr, rdata, err, lat);
      check($sformatf("v%0d.rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d.err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      check($sformatf("v%0d.latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d.sel", i), {30'b0, sel_first}, {30'b0, vecs[i].exp_sel});
      check($sformatf("v%0d.sel_at_rsp", i), {30'b0, sel_at_rsp}, 32'h3);
      check($sformatf("v%0d.ready_at_rsp", i), {31'b0, ready_at_rsp}, 32'h0);
      check($sformatf("v%0d.after_rsp", i), {31'b0, after_ok}, 32'h1);
      check($sformatf("v%0d.led", i), {16'b0, led_out}, {16'b0, vecs[i].exp_led});
    end

    // back-to-back: req_valid held high, next accept only after rsp_valid
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_4000;
    for (int k = 0; k < 9; k++) begin
      rdy_seen[k] = req_ready;
      rsp_seen[k] = rsp_valid;
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    $display("txn b2b ready=%b rsp=%b", rdy_seen, rsp_seen);
    check("b2b.ready_pattern", {23'b0, rdy_seen}, 32'h049);
    check("b2b.rsp_pattern", {23'b0, rsp_seen}, 32'h124);

    // stray acks while idle
    cnt = 0;
    mem_ack = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid || mem_sel_n != 2'b11) cnt++;
      if (k == 2) mem_ack = 2'b00;
    end
    $display("txn stray_ack events=%0d", cnt);
    check("stray_ack.events", cnt, 0);

    // reset in the middle of a bank wait
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0002_0000;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst.sel_before", {30'b0, mem_sel_n}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    $display("txn midrst sel=%b ready=%0b led=%h", mem_sel_n, req_ready, led_out);
    check("midrst.sel", {30'b0, mem_sel_n}, 32'h3);
    check("midrst.ready", {31'b0, req_ready}, 32'h1);
    check("midrst.led", {16'b0, led_out}, 32'h0);
    check("midrst.rsp_valid", {31'b0, rsp_valid}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check("midrst.no_rsp", cnt, 0);

    // four-bank build: bank index from addr[18:17], higher bits alias
    for (int i = 0; i < 4; i++) begin
      req_valid4 = 1'b1; req_addr4 = a4[i];
      @(negedge clk);
      req_valid4 = 1'b0;
      check($sformatf("n4_%0d.sel", i), {28'b0, mem_sel_n4}, {28'b0, e4[i]});
      mem_ack4 = ~e4[i];
      guard = 0;
      while (!rsp_valid4 && guard < 10) begin
        @(negedge clk);
        mem_ack4 = 4'b0000;
        guard++;
      end
      mem_ack4 = 4'b0000;
      $display("txn n4_%0d addr=%h sel=%b rdata=%h", i, a4[i], mem_sel_n4, rsp_rdata4);
      check($sformatf("n4_%0d.rsp_valid", i), {31'b0, rsp_valid4}, 32'h1);
      check($sformatf("n4_%0d.rdata", i), rsp_rdata4, d4[i]);
      check($sformatf("n4_%0d.err", i), {31'b0, rsp_err4}, 32'h0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
